// File: rtl/axi_mm_resp_pkg.sv
// rtl/axi_mm_resp_pkg.sv - shared types and constants for the AXI4 memory responder
//
// Purpose : response codes, write/read FSM state types, line geometry and
//           the address-window test used by both channel paths.
// Ports   : none (package).
package axi_mm_resp_pkg;

    localparam int LINE_BYTES = 64;
    localparam int LINE_SHIFT = 6;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } rd_state_t;

    // A beat is served only when it lies inside [base, base + span).
    // The offset is kept at full 64-bit width so addresses far beyond the
    // array never alias back into it.
    function automatic logic in_window(input logic [63:0] addr,
                                       input logic [63:0] base,
                                       input logic [63:0] span);
        return (addr >= base) && ((addr - base) < span);
    endfunction

endpackage

// File: rtl/axi_mm_resp_rd_ch.sv
// rtl/axi_mm_resp_rd_ch.sv - read channel: AR capture, latency wait, registered R beats
//
// Purpose : accepts one AR burst at a time, waits READ_LAT cycles, then
//           streams len+1 INCR beats from the line array.
// Ports   : clk/rst_n          clock, async active-low reset
//           ar*                AR channel (arlen already trimmed to 8 bits)
//           r*                 R channel outputs, rready input
//           rd_idx / rd_line   combinational line-array read port
import axi_mm_resp_pkg::*;

module axi_mm_resp_rd_ch #(
    parameter logic [63:0] BASE_ADDR  = 64'h0,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          ID_W       = 12,
    parameter int          READ_LAT   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_W-1:0]       arid,
    input  logic [63:0]           araddr,
    input  logic [7:0]            arlen,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_W-1:0]       rid,
    output logic [511:0]          rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DEPTH_LOG2-1:0] rd_idx,
    input  logic [511:0]          rd_line
);

    localparam logic [63:0] SPAN   = 64'(1 << DEPTH_LOG2) * 64'(LINE_BYTES);
    localparam logic [3:0]  LAT_M1 = 4'((READ_LAT > 0) ? READ_LAT - 1 : 0);

    rd_state_t   state;
    logic [63:0] nxt_addr;
    logic [7:0]  len;
    logic [7:0]  beat;
    logic [3:0]  wcnt;

    logic [63:0]  rd_addr;
    logic         rd_in_range;
    logic [511:0] ld_data;
    logic [1:0]   ld_resp;

    // In idle the array is addressed straight from araddr so that a
    // zero-latency configuration can load beat 0 on the AR fire edge.
    assign rd_addr     = (state == R_IDLE) ? araddr : nxt_addr;
    assign rd_in_range = in_window(rd_addr, BASE_ADDR, SPAN);
    assign rd_idx      = DEPTH_LOG2'((rd_addr - BASE_ADDR) >> LINE_SHIFT);
    assign ld_data     = rd_in_range ? rd_line : '0;
    assign ld_resp     = rd_in_range ? RESP_OKAY : RESP_DECERR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= R_IDLE;
            arready  <= 1'b1;
            rid      <= '0;
            rdata    <= '0;
            rresp    <= '0;
            rlast    <= 1'b0;
            rvalid   <= 1'b0;
            nxt_addr <= '0;
            len      <= '0;
            beat     <= '0;
            wcnt     <= '0;
        end else begin
            case (state)
                R_IDLE: begin
                    if (arvalid) begin
                        rid     <= arid;
                        len     <= arlen;
                        beat    <= '0;
                        arready <= 1'b0;
                        if (READ_LAT == 0) begin
                            rdata    <= ld_data;
                            rresp    <= ld_resp;
                            rvalid   <= 1'b1;
                            rlast    <= (arlen == 8'd0);
                            nxt_addr <= araddr + 64'(LINE_BYTES);
                            state    <= R_DATA;
                        end else begin
                            nxt_addr <= araddr;
                            wcnt     <= '0;
                            state    <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (wcnt == LAT_M1) begin
                        rdata    <= ld_data;
                        rresp    <= ld_resp;
                        rvalid   <= 1'b1;
                        rlast    <= (len == 8'd0);
                        nxt_addr <= nxt_addr + 64'(LINE_BYTES);
                        state    <= R_DATA;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                R_DATA: begin
                    // Outputs only move on a fire, so they hold under backpressure.
                    if (rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            state   <= R_IDLE;
                        end else begin
                            beat     <= beat + 8'd1;
                            rdata    <= ld_data;
                            rresp    <= ld_resp;
                            rlast    <= ((beat + 8'd1) == len);
                            nxt_addr <= nxt_addr + 64'(LINE_BYTES);
                        end
                    end
                end
                default: begin
                    state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/axi_mm_resp_mem.sv
// rtl/axi_mm_resp_mem.sv - AXI4 memory responder backed by a 64B-line array
//
// Purpose : serves INCR write and read bursts against 2^DEPTH_LOG2 lines
//           starting at BASE_ADDR, echoing IDs and returning DECERR for
//           beats outside the window.
// Ports   : axi4_mm_clk / axi4_mm_rst_n   clock, async active-low reset
//           aw* / w* / b*                 write address, data, response
//           ar* / r*                      read address, data
import axi_mm_resp_pkg::*;

module axi_mm_resp_mem #(
    parameter logic [63:0] BASE_ADDR  = 64'h0,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          ID_W       = 12,
    parameter int          READ_LAT   = 2
) (
    input  logic            axi4_mm_clk,
    input  logic            axi4_mm_rst_n,
    input  logic [ID_W-1:0] awid,
    input  logic [63:0]     awaddr,
    input  logic [9:0]      awlen,
    input  logic            awvalid,
    output logic            awready,
    input  logic [511:0]    wdata,
    input  logic [63:0]     wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready,
    input  logic [ID_W-1:0] arid,
    input  logic [63:0]     araddr,
    input  logic [9:0]      arlen,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [511:0]    rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready
);

    localparam int          LINES = 1 << DEPTH_LOG2;
    localparam logic [63:0] SPAN  = 64'(LINES) * 64'(LINE_BYTES);

    logic [511:0] mem [0:LINES-1];

    wr_state_t       wr_state;
    logic [63:0]     w_addr;
    logic [7:0]      w_len;
    logic [7:0]      w_beat;
    logic            w_dec;
    logic            w_slv;

    logic                  w_fire;
    logic                  w_in_range;
    logic                  w_final;
    logic                  w_last_bad;
    logic [DEPTH_LOG2-1:0] w_idx;

    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [511:0]          rd_line;

    // Upper length bits are outside the 256-beat burst range and are dropped.
    logic unused_len_bits;
    assign unused_len_bits = ^{awlen[9:8], arlen[9:8]};

    assign w_fire     = wvalid & wready;
    assign w_in_range = in_window(w_addr, BASE_ADDR, SPAN);
    assign w_idx      = DEPTH_LOG2'((w_addr - BASE_ADDR) >> LINE_SHIFT);
    assign w_final    = (w_beat == w_len);
    // wlast is only checked, never used to end the burst.
    assign w_last_bad = (wlast != w_final);

    always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
        if (!axi4_mm_rst_n) begin
            wr_state <= W_IDLE;
            awready  <= 1'b1;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bid      <= '0;
            bresp    <= '0;
            w_addr   <= '0;
            w_len    <= '0;
            w_beat   <= '0;
            w_dec    <= 1'b0;
            w_slv    <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (awvalid) begin
                        bid      <= awid;
                        w_addr   <= awaddr;
                        w_len    <= awlen[7:0];
                        w_beat   <= '0;
                        w_dec    <= 1'b0;
                        w_slv    <= 1'b0;
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        wr_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        w_beat <= w_beat + 8'd1;
                        w_addr <= w_addr + 64'(LINE_BYTES);
                        if (w_final) begin
                            wready   <= 1'b0;
                            bvalid   <= 1'b1;
                            wr_state <= W_RESP;
                            // DECERR outranks SLVERR; fold in the final beat here.
                            if (w_dec || !w_in_range)
                                bresp <= RESP_DECERR;
                            else if (w_slv || w_last_bad)
                                bresp <= RESP_SLVERR;
                            else
                                bresp <= RESP_OKAY;
                        end else begin
                            w_dec <= w_dec | !w_in_range;
                            w_slv <= w_slv | w_last_bad;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid   <= 1'b0;
                        awready  <= 1'b1;
                        wr_state <= W_IDLE;
                    end
                end
                default: begin
                    wr_state <= W_IDLE;
                end
            endcase
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge axi4_mm_clk) begin
        if (w_fire && w_in_range) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (wstrb[b])
                    mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Combinational read: a same-cycle write lands after the R register samples,
    // so the read sees the pre-write line.
    assign rd_line = mem[rd_idx];

    axi_mm_resp_rd_ch #(
        .BASE_ADDR  (BASE_ADDR),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .ID_W       (ID_W),
        .READ_LAT   (READ_LAT)
    ) u_rd_ch (
        .clk     (axi4_mm_clk),
        .rst_n   (axi4_mm_rst_n),
        .arid    (arid),
        .araddr  (araddr),
        .arlen   (arlen[7:0]),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready),
        .rd_idx  (rd_idx),
        .rd_line (rd_line)
    );

endmodule

// File: tb/tb_axi_mm_resp_mem.sv
// tb/tb_axi_mm_resp_mem.sv - scoreboard bench for the AXI4 memory responder
module tb_axi_mm_resp_mem;

    localparam int          ID_W = 12;
    localparam logic [63:0] BASE = 64'h0;
    localparam logic [63:0] SPAN = 64'd1024 * 64'd64;
    localparam logic [63:0] TOP_LINE = BASE + SPAN - 64'd64;
    localparam logic [1:0]  OKAY = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;
    localparam logic [1:0]  DECERR = 2'b11;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [ID_W-1:0] awid, arid, bid, rid;
    logic [63:0]     awaddr, araddr;
    logic [9:0]      awlen, arlen;
    logic            awvalid, awready, arvalid, arready;
    logic [511:0]    wdata, rdata;
    logic [63:0]     wstrb;
    logic            wlast, wvalid, wready;
    logic [1:0]      bresp, rresp;
    logic            bvalid, bready, rlast, rvalid, rready;

    always #5 clk = ~clk;

    axi_mm_resp_mem #(
        .BASE_ADDR  (BASE),
        .DEPTH_LOG2 (10),
        .ID_W       (ID_W),
        .READ_LAT   (2)
    ) dut (
        .axi4_mm_clk   (clk),
        .axi4_mm_rst_n (rst_n),
        .awid    (awid),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bid     (bid),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .arid    (arid),
        .araddr  (araddr),
        .arlen   (arlen),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    typedef struct {
        logic [ID_W-1:0] id;
        logic [511:0]    data;
        logic [1:0]      resp;
        logic            last;
    } r_exp_t;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_exp_t;

    r_exp_t rq[$];
    b_exp_t bq[$];
    r_exp_t er;
    b_exp_t eb;

    int vectors = 0;
    int miscompares = 0;

    logic [511:0] model [0:1023];
    logic [511:0] w_data [0:15];
    logic [63:0]  w_strb [0:15];
    logic         w_last [0:15];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timeout waiting on DUT", name);
    endtask

    function automatic logic [511:0] pat(input int n);
        logic [511:0] r;
        logic [31:0]  w;
        w = 32'h1357_0000 + 32'(n) * 32'h0001_0203;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = w ^ 32'(i * 32'h0101_0101);
        return r;
    endfunction

    function automatic logic addr_ok(input logic [63:0] a);
        return (a >= BASE) && ((a - BASE) < SPAN);
    endfunction

    // Monitors: pop one expectation per handshake observed.
    always @(negedge clk) begin
        if (rst_n && rvalid && rready) begin
            if (rq.size() == 0) begin
                timeout("r_unexpected_beat");
            end else begin
                er = rq.pop_front();
                check("rid", 512'(rid), 512'(er.id));
                check("rdata", rdata, er.data);
                check("rresp", 512'(rresp), 512'(er.resp));
                check("rlast", 512'(rlast), 512'(er.last));
            end
        end
        if (rst_n && bvalid && bready) begin
            if (bq.size() == 0) begin
                timeout("b_unexpected_resp");
            end else begin
                eb = bq.pop_front();
                check("bid", 512'(bid), 512'(eb.id));
                check("bresp", 512'(bresp), 512'(eb.resp));
            end
        end
    end

    task automatic set_w(input int len, input int seed);
        for (int b = 0; b <= len; b++) begin
            w_data[b] = pat(seed + b);
            w_strb[b] = '1;
            w_last[b] = (b == len);
        end
    endtask

    task automatic write_burst(input logic [ID_W-1:0] id, input logic [63:0] addr,
                               input int len, input logic [1:0] exp_resp);
        int n;
        logic [63:0] a;
        bq.push_back('{id: id, resp: exp_resp});
        awid = id; awaddr = addr; awlen = 10'(len); awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 200);
        if (!awready) timeout("aw_handshake");
        @(posedge clk); #1 awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            wdata = w_data[b]; wstrb = w_strb[b]; wlast = w_last[b]; wvalid = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!wready && n < 200);
            if (!wready) timeout("w_handshake");
            @(posedge clk); #1;
            a = addr + 64'(b) * 64'd64;
            if (addr_ok(a))
                for (int k = 0; k < 64; k++)
                    if (w_strb[b][k]) model[int'((a - BASE) >> 6)][8*k +: 8] = w_data[b][8*k +: 8];
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic read_burst(input logic [ID_W-1:0] id, input logic [63:0] addr,
                              input int len, output int lat);
        int n;
        logic [63:0] a;
        for (int b = 0; b <= len; b++) begin
            a = addr + 64'(b) * 64'd64;
            if (addr_ok(a))
                rq.push_back('{id: id, data: model[int'((a - BASE) >> 6)], resp: OKAY, last: (b == len)});
            else
                rq.push_back('{id: id, data: '0, resp: DECERR, last: (b == len)});
        end
        arid = id; araddr = addr; arlen = 10'(len); arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 200);
        if (!arready) timeout("ar_handshake");
        @(posedge clk); #1 arvalid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rvalid && lat < 200);
        if (!rvalid) timeout("rvalid_first");
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 500) begin
            @(posedge clk); n++;
        end
        if (rq.size() != 0 || bq.size() != 0) timeout("scoreboard_drain");
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 512'(awready), 512'(1));
        check("rst_arready", 512'(arready), 512'(1));
        check("rst_wready", 512'(wready), 512'(0));
        check("rst_bvalid", 512'(bvalid), 512'(0));
        check("rst_rvalid", 512'(rvalid), 512'(0));
        check("rst_rlast", 512'(rlast), 512'(0));
        check("rst_ids", 512'({bid, rid}), 512'(0));
        check("rst_resps", 512'({bresp, rresp}), 512'(0));
        check("rst_rdata", rdata, 512'(0));
        @(posedge clk); #1 rst_n = 1'b1;

        // Single-beat write/read with B held under backpressure, then latency.
        bready = 1'b0;
        set_w(0, 1);
        write_burst(12'd5, BASE + 64'h40, 0, OKAY);
        repeat (3) begin
            @(negedge clk);
            check("bvalid_hold", 512'(bvalid), 512'(1));
        end
        @(posedge clk); #1 bready = 1'b1;
        wait_empty();
        read_burst(12'd7, BASE + 64'h40, 0, lat);
        check("read_latency", 512'(lat), 512'(3));
        wait_empty();

        // 4-beat fill, then byte-0-only strobe on beat 2, then read back.
        set_w(3, 10);
        write_burst(12'd1, BASE, 3, OKAY);
        set_w(3, 99);
        for (int b = 0; b < 4; b++) w_strb[b] = (b == 2) ? 64'h1 : 64'h0;
        write_burst(12'd2, BASE, 3, OKAY);
        read_burst(12'd3, BASE, 3, lat);
        wait_empty();

        // Window top edge: second beat falls off the end.
        set_w(0, 50);
        write_burst(12'd4, TOP_LINE, 0, OKAY);
        read_burst(12'd8, TOP_LINE, 1, lat);
        wait_empty();
        set_w(1, 60);
        write_burst(12'd6, TOP_LINE, 1, DECERR);
        wait_empty();
        read_burst(12'd9, BASE, 0, lat);
        read_burst(12'd10, TOP_LINE, 0, lat);
        wait_empty();

        // R stall for 5 cycles mid-burst while a write burst runs.
        fork
            begin
                int n;
                rready = 1'b1;
                read_burst(12'd12, BASE, 3, lat);
                n = 0;
                while (rq.size() > 2 && n < 200) begin @(posedge clk); n++; end
                #1 rready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_rvalid", 512'(rvalid), 512'(1));
                    if (rq.size() > 0) begin
                        check("stall_rdata", rdata, rq[0].data);
                        check("stall_rresp", 512'(rresp), 512'(rq[0].resp));
                        check("stall_rlast", 512'(rlast), 512'(rq[0].last));
                    end
                end
                check("b_done_during_stall", 512'(bq.size()), 512'(0));
                @(posedge clk); #1 rready = 1'b1;
            end
            begin
                set_w(1, 70);
                write_burst(12'd13, BASE + 64'd640, 1, OKAY);
            end
        join
        wait_empty();

        // Early wlast on beat 1 of a 3-beat burst.
        set_w(2, 80);
        w_last[1] = 1'b1;
        write_burst(12'd15, BASE + 64'd1280, 2, SLVERR);
        read_burst(12'd16, BASE + 64'd1280, 2, lat);
        wait_empty();

        // Reset while beat 2 of 4 is presented.
        rready = 1'b0;
        read_burst(12'd11, BASE, 3, lat);
        @(posedge clk); #1 rready = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 rready = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_rvalid", 512'(rvalid), 512'(0));
        check("midrst_arready", 512'(arready), 512'(1));
        check("midrst_awready", 512'(awready), 512'(1));
        check("midrst_remaining", 512'(rq.size()), 512'(2));
        rq.delete();
        @(posedge clk); #1 rst_n = 1'b1; rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        read_burst(12'd14, BASE + 64'd1344, 0, lat);
        check("post_rst_latency", 512'(lat), 512'(3));
        wait_empty();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_mm_resp_mem.md
Name: axi_mm_resp_mem

Overview:
AXI4 memory responder (subordinate) for the core's 512-bit host-memory AXI master (aw/w/b/ar/r). It stands in for host memory in the simulator and the FPGA loopback. It serves INCR bursts from an internal 64B-line array, echoes IDs, and returns DECERR outside its window.

Parameters:
BASE_ADDR, 64'h0, byte address of line 0
DEPTH_LOG2, 10, log2 of line count (64B lines)
ID_W, 12, AXI ID width
READ_LAT, 2, idle cycles from AR accept to first rvalid (0..15)

Ports:
axi4_mm_clk  in  1  clock
axi4_mm_rst_n  in  1  asynchronous active-low reset
awid  in  ID_W  write ID
awaddr  in  64  byte address
awlen  in  10  beats-1 (0..255 used)
awvalid/awready  in/out  1  AW handshake
wdata  in  512  write data
wstrb  in  64  byte enables
wlast  in  1  last beat
wvalid/wready  in/out  1  W handshake
bid  out  ID_W  = captured awid
bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
bvalid/bready  out/in  1  B handshake
arid  in  ID_W  read ID
araddr  in  64  byte address
arlen  in  10  beats-1
arvalid/arready  in/out  1  AR handshake
rid  out  ID_W  = captured arid
rdata  out  512  read data
rresp  out  2  per-beat response
rlast  out  1  final beat
rvalid/rready  out/in  1  R handshake

Behaviour:
- Reset: awready=1, arready=1; wready, bvalid, rvalid, rlast=0; bid, rid, rdata, bresp, rresp=0. The array is not reset. Reset mid-burst abandons the burst; no B or R is issued afterwards.
- Addressing: off=addr-BASE_ADDR (64-bit). Line = off[DEPTH_LOG2+5:6]. addr[5:0] ignored. A beat is in range iff addr>=BASE_ADDR and off < 2^DEPTH_LOG2*64. Every burst is INCR (+64B per beat) regardless of awburst/arburst. arlen/awlen[9:8] are ignored.
- Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE. awready=W_IDLE. On AW fire, capture id, addr, len. wready=W_DATA, which means W is never accepted before AW.
- Write beats: each W fire writes bytes where wstrb=1 to the current line, provided the beat is in range. The beat counter increments.
- Write burst end: the burst ends after len+1 beats; wlast does not terminate it early. bresp=DECERR if any beat was out of range, else SLVERR if wlast mismatched on any beat (1 on a non-final beat, 0 on the final beat), else OKAY. bvalid is asserted the cycle after the final W fire and held until bready.
- Read FSM R_IDLE->R_WAIT->R_DATA->R_IDLE. arready=R_IDLE. R_WAIT lasts READ_LAT cycles and is skipped when READ_LAT=0, giving first rvalid the cycle after the AR fire.
- Read beats: rdata and rresp are registered and held stable while rvalid & !rready. Each R fire loads the next line. An out-of-range beat returns rdata=0 with rresp=DECERR. rlast=1 only on beat len.
- Read/write independence: the read and write paths run concurrently. A read of a line written in the same cycle returns the pre-write contents. A later beat sees the new contents.
- Counters: beat counters are 8 bits. The line index wraps modulo 2^DEPTH_LOG2 only inside the array; the range check uses the full 64-bit offset.

Decomposition:
- Package axi_mm_resp_pkg: resp_t constants (OKAY/SLVERR/DECERR), wr_state_t, rd_state_t, LINE_BYTES=64.
- One sub-module, axi_mm_resp_rd_ch: the read FSM with its latency counter and R output register, reading the array through a combinational index/data port.

Test Plan:
- AW(id=5, addr=BASE+0x40, len=0) + W(all-ones strb, data=A) -> bid=5, bresp=OKAY. Then AR(id=7, same addr) -> rid=7, rdata=A, rlast=1, rvalid first seen 3 cycles after the AR fire (READ_LAT=2).
- 4-beat write at BASE with wstrb=64'h1 on beat 2 -> only byte 0 of line 2 changes. A 4-beat read returns 4 beats, rlast set only on the 4th.
- AR at BASE+2^DEPTH_LOG2*64-64 with len=1 -> beat0 OKAY with data, beat1 rdata=0 and DECERR. A write over the same range -> bresp=DECERR and no write to line 0.
- rready low for 5 cycles mid-burst -> rdata, rresp and rlast stable. Concurrent write burst to another line completes with bvalid meanwhile.
- wlast=1 on beat 1 of a len=2 burst -> 3 beats accepted, bresp=SLVERR.
- Reset pulse during R_DATA beat 2 of 4 -> next cycle rvalid=0, arready=1. A new AR is served correctly.
